// File: rtl/read_pointer_control.sv
// read_pointer_control: read-side pointer control for the RX elastic buffer.
// Define EB_SKP_INSERT_EN to build SKP insertion (one re-read of a SKP when occupancy is low).
module read_pointer_control #(
  parameter int DATA_WIDTH    = 10,
  parameter int BUFFER_DEPTH  = 16,
  parameter int LOW_WATERMARK = 6,
  localparam int A = $clog2(BUFFER_DEPTH)
) (
  input  logic                  read_clk,
  input  logic                  rst_n,
  input  logic [A:0]            gray_write_pointer,
  input  logic [DATA_WIDTH-1:0] read_data,
  input  logic                  read_enable,
  input  logic                  buffer_mode,
  output logic                  underflow,
  output logic                  Skp_Added,
  output logic [A:0]            read_address,
  output logic [A:0]            gray_read_pointer,
  output logic [A:0]            occupancy
);

  localparam logic [DATA_WIDTH-1:0] SKP_POS = DATA_WIDTH'(10'b0011111001);
  localparam logic [DATA_WIDTH-1:0] SKP_NEG = DATA_WIDTH'(10'b1100000110);
  localparam logic [A+1:0]          LOW_WM  = (A+2)'(LOW_WATERMARK);

  logic [A:0] sync1_reg;
  logic [A:0] sync2_reg;
  logic [A:0] sync_wp_bin;
  logic [A:0] read_address_reg;
  logic [A:0] read_address_next;
  logic       empty;
  logic       skp_symbol;
  logic       low_occ;
  logic       insert;

  // Two-flop synchroniser; Gray coding keeps each captured value within one step of truth.
  always_ff @(posedge read_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= gray_write_pointer;
      sync2_reg <= sync1_reg;
    end
  end

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  for (genvar gi = 0; gi <= A; gi++) begin : g_gray2bin
    assign sync_wp_bin[gi] = ^sync2_reg[A:gi];
  end

  assign gray_read_pointer = read_address_reg ^ (read_address_reg >> 1);
  assign empty             = (gray_read_pointer == sync2_reg);
  assign underflow         = rst_n & empty;
  assign occupancy         = sync_wp_bin - read_address_reg;
  assign read_address      = read_address_reg;

  assign skp_symbol = (read_data == SKP_POS) || (read_data == SKP_NEG);
  assign low_occ    = ({1'b0, occupancy} < LOW_WM);

`ifdef EB_SKP_INSERT_EN
  logic hold_flag_reg;
  logic hold_flag_next;
  logic skp_added_reg;
  logic skp_added_next;

  assign insert = read_enable && !empty && !buffer_mode && skp_symbol
                  && low_occ && !hold_flag_reg;

  // hold_flag remembers that the SKP under the pointer was already duplicated once.
  always_comb begin
    hold_flag_next = hold_flag_reg;
    skp_added_next = 1'b0;
    if (read_enable && !empty) begin
      if (insert) begin
        hold_flag_next = 1'b1;
        skp_added_next = 1'b1;
      end else begin
        hold_flag_next = 1'b0;
      end
    end
  end

  always_ff @(posedge read_clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_flag_reg <= 1'b0;
      skp_added_reg <= 1'b0;
    end else begin
      hold_flag_reg <= hold_flag_next;
      skp_added_reg <= skp_added_next;
    end
  end

  assign Skp_Added = skp_added_reg;
`else
  logic unused_insert_inputs;
  assign unused_insert_inputs = ^{skp_symbol, low_occ, buffer_mode};
  assign insert    = 1'b0;
  assign Skp_Added = 1'b0;
`endif

  always_comb begin
    read_address_next = read_address_reg;
    if (read_enable && !empty && !insert) begin
      read_address_next = read_address_reg + 1'b1;
    end
  end

  always_ff @(posedge read_clk or negedge rst_n) begin
    if (!rst_n) begin
      read_address_reg <= '0;
    end else begin
      read_address_reg <= read_address_next;
    end
  end

endmodule

// File: tb/tb_read_pointer_control.sv
// Self-checking bench for read_pointer_control; expectations come from a behavioural model via a scoreboard queue.
module tb_read_pointer_control;

  localparam int DW = 10;
  localparam int A  = 4;
  localparam logic [DW-1:0] SKP_P  = 10'b0011111001;
  localparam logic [DW-1:0] SKP_N  = 10'b1100000110;
  localparam logic [DW-1:0] NONSKP = 10'h155;
`ifdef EB_SKP_INSERT_EN
  localparam int INS_ON = 1;
`else
  localparam int INS_ON = 0;
`endif

  typedef struct packed {
    logic [A:0] addr;
    logic       skp;
    logic       uf;
    logic [A:0] occ;
  } exp_t;

  logic          read_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [A:0]    gray_write_pointer = '0;
  logic [DW-1:0] read_data;
  logic          read_enable = 1'b0;
  logic          buffer_mode = 1'b0;
  logic          underflow;
  logic          Skp_Added;
  logic [A:0]    read_address;
  logic [A:0]    gray_read_pointer;
  logic [A:0]    occupancy;

  logic [DW-1:0] mem [16];
  exp_t          sb[$];
  logic [A:0]    m_addr, m_s1, m_s2;
  logic          m_hold, m_skp;
  int            n_checks = 0;
  int            n_fail = 0;

  read_pointer_control dut (
    .read_clk          (read_clk),
    .rst_n             (rst_n),
    .gray_write_pointer(gray_write_pointer),
    .read_data         (read_data),
    .read_enable       (read_enable),
    .buffer_mode       (buffer_mode),
    .underflow         (underflow),
    .Skp_Added         (Skp_Added),
    .read_address      (read_address),
    .gray_read_pointer (gray_read_pointer),
    .occupancy         (occupancy)
  );

  always #5 read_clk = ~read_clk;
  assign read_data = mem[read_address[3:0]];

  function automatic logic [A:0] b2g(input logic [A:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [A:0] g2b(input logic [A:0] g);
    logic [A:0] b;
    b[A] = g[A];
    for (int i = A - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic model_reset();
    m_addr = '0; m_s1 = '0; m_s2 = '0; m_hold = 1'b0; m_skp = 1'b0;
    sb.delete();
  endtask

  // Drive one cycle, push the model's post-edge expectation, then wait past the edge.
  task automatic drive_cycle(input logic en, input logic mode, input logic [A:0] wp_bin);
    logic [A:0] wb;
    logic       emp, skp, ins;
    exp_t       e;
    read_enable        = en;
    buffer_mode        = mode;
    gray_write_pointer = b2g(wp_bin);
    wb  = g2b(m_s2);
    emp = (wb == m_addr);
    skp = (mem[m_addr[3:0]] == SKP_P) || (mem[m_addr[3:0]] == SKP_N);
    ins = en && !emp && !mode && skp && ((wb - m_addr) < 5'd6) && !m_hold;
    if (INS_ON == 0) ins = 1'b0;
    m_skp = ins;
    if (en && !emp) begin
      if (ins) m_hold = 1'b1;
      else begin m_addr = m_addr + 1'b1; m_hold = 1'b0; end
    end
    m_s2 = m_s1;
    m_s1 = b2g(wp_bin);
    e.addr = m_addr;
    e.skp  = m_skp;
    e.uf   = (g2b(m_s2) == m_addr);
    e.occ  = g2b(m_s2) - m_addr;
    sb.push_back(e);
    @(posedge read_clk);
    #1;
    $display("t=%0t en=%0b mode=%0b gwp_bin=%0d addr=%0d gray=%0d skp_added=%0b underflow=%0b occ=%0d",
             $time, en, mode, wp_bin, read_address, gray_read_pointer, Skp_Added, underflow, occupancy);
  endtask

  task automatic test_reset();
    exp_t e;
    model_reset();
    rst_n = 1'b0;
    gray_write_pointer = '0;
    #12;
    n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL reset.underflow: got %0b want 0", underflow); end
    n_checks++; if (read_address !== 5'd0) begin n_fail++; $display("FAIL reset.addr: got %0d want 0", read_address); end
    n_checks++; if (Skp_Added !== 1'b0) begin n_fail++; $display("FAIL reset.skp: got %0b want 0", Skp_Added); end
    n_checks++; if (gray_read_pointer !== 5'd0) begin n_fail++; $display("FAIL reset.gray: got %0d want 0", gray_read_pointer); end
    n_checks++; if (occupancy !== 5'd0) begin n_fail++; $display("FAIL reset.occ: got %0d want 0", occupancy); end
    rst_n = 1'b1;
    #1;
    n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL release.underflow: got %0b want 1", underflow); end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 1'b0, 5'd0);
      e = sb.pop_front();
      n_checks++; if (read_address !== e.addr) begin n_fail++; $display("FAIL idle.addr: got %0d want %0d", read_address, e.addr); end
      n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL idle.underflow: got %0b want 1", underflow); end
    end
  endtask

  task automatic test_fill_drain();
    exp_t e;
    for (int i = 0; i < 9; i++) begin
      drive_cycle(1'b1, 1'b0, 5'd5);
      e = sb.pop_front();
      n_checks++; if (read_address !== e.addr) begin n_fail++; $display("FAIL fill.addr: got %0d want %0d", read_address, e.addr); end
      n_checks++; if (occupancy !== e.occ) begin n_fail++; $display("FAIL fill.occ: got %0d want %0d", occupancy, e.occ); end
      n_checks++; if (underflow !== e.uf) begin n_fail++; $display("FAIL fill.underflow: got %0b want %0b", underflow, e.uf); end
      if (i == 1) begin
        n_checks++; if (occupancy !== 5'd5) begin n_fail++; $display("FAIL fill.occ_seen: got %0d want 5", occupancy); end
      end
    end
    n_checks++; if (read_address !== 5'd5) begin n_fail++; $display("FAIL fill.final_addr: got %0d want 5", read_address); end
    n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL fill.final_underflow: got %0b want 1", underflow); end
  endtask

  task automatic test_skp_insert();
    exp_t e;
    int   pulses = 0;
    mem[5] = SKP_P;
    for (int i = 0; i < 2; i++) begin drive_cycle(1'b0, 1'b0, 5'd8); e = sb.pop_front(); end
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b1, 1'b0, 5'd8);
      e = sb.pop_front();
      if (Skp_Added === 1'b1) pulses++;
      n_checks++; if (read_address !== e.addr) begin n_fail++; $display("FAIL skp.addr: got %0d want %0d", read_address, e.addr); end
      n_checks++; if (Skp_Added !== e.skp) begin n_fail++; $display("FAIL skp.skp_added: got %0b want %0b", Skp_Added, e.skp); end
    end
    n_checks++; if (pulses != INS_ON) begin n_fail++; $display("FAIL skp.count: got %0d want %0d", pulses, INS_ON); end
    n_checks++; if (read_address !== 5'd8) begin n_fail++; $display("FAIL skp.final_addr: got %0d want 8", read_address); end
    mem[5] = NONSKP;
  endtask

  task automatic test_no_insert();
    exp_t e;
    int   pulses = 0;
    mem[8] = SKP_N;
    for (int i = 0; i < 2; i++) begin drive_cycle(1'b0, 1'b1, 5'd11); e = sb.pop_front(); end
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b1, 1'b1, 5'd11);
      e = sb.pop_front();
      if (Skp_Added === 1'b1) pulses++;
      n_checks++; if (read_address !== e.addr) begin n_fail++; $display("FAIL mode1.addr: got %0d want %0d", read_address, e.addr); end
    end
    mem[8] = NONSKP;
    mem[11] = SKP_P;
    for (int i = 0; i < 2; i++) begin drive_cycle(1'b0, 1'b0, 5'd19); e = sb.pop_front(); end
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b1, 1'b0, 5'd19);
      e = sb.pop_front();
      if (Skp_Added === 1'b1) pulses++;
      n_checks++; if (read_address !== e.addr) begin n_fail++; $display("FAIL occ8.addr: got %0d want %0d", read_address, e.addr); end
      n_checks++; if (occupancy !== e.occ) begin n_fail++; $display("FAIL occ8.occ: got %0d want %0d", occupancy, e.occ); end
    end
    mem[11] = NONSKP;
    n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL noins.count: got %0d want 0", pulses); end
    n_checks++; if (read_address !== 5'd19) begin n_fail++; $display("FAIL noins.final_addr: got %0d want 19", read_address); end
  endtask

  task automatic test_wrap();
    exp_t       e;
    logic [A:0] prev_gray, prev_addr;
    logic       saw_31_0 = 1'b0;
    logic       saw_15_16 = 1'b0;
    for (int i = 0; i < 2; i++) begin drive_cycle(1'b0, 1'b0, 5'd23); e = sb.pop_front(); end
    prev_gray = gray_read_pointer;
    prev_addr = read_address;
    for (int i = 0; i < 40; i++) begin
      drive_cycle(1'b1, 1'b0, m_addr + 5'd4);
      e = sb.pop_front();
      n_checks++; if (read_address !== e.addr) begin n_fail++; $display("FAIL wrap.addr: got %0d want %0d", read_address, e.addr); end
      n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL wrap.underflow: got %0b want 0", underflow); end
      n_checks++; if ($countones(gray_read_pointer ^ prev_gray) != 1) begin
        n_fail++; $display("FAIL wrap.gray_step: got %0d after %0d want one-bit change", gray_read_pointer, prev_gray);
      end
      if (prev_addr == 5'd31 && read_address == 5'd0) saw_31_0 = 1'b1;
      if (prev_addr == 5'd15 && read_address == 5'd16) saw_15_16 = 1'b1;
      prev_gray = gray_read_pointer;
      prev_addr = read_address;
    end
    n_checks++; if (saw_31_0 !== 1'b1) begin n_fail++; $display("FAIL wrap.31to0: got %0b want 1", saw_31_0); end
    n_checks++; if (saw_15_16 !== 1'b1) begin n_fail++; $display("FAIL wrap.15to16: got %0b want 1", saw_15_16); end
    n_checks++; if (read_address !== 5'd27) begin n_fail++; $display("FAIL wrap.final_addr: got %0d want 27", read_address); end
  endtask

  task automatic test_reset_midstream();
    exp_t e;
    int   pulses = 0;
    rst_n = 1'b0;
    model_reset();
    #4;
    rst_n = 1'b1;
    mem[9] = SKP_P;
    for (int i = 0; i < 2; i++) begin drive_cycle(1'b0, 1'b0, 5'd12); e = sb.pop_front(); end
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b1, 1'b0, 5'd12);
      e = sb.pop_front();
      n_checks++; if (read_address !== e.addr) begin n_fail++; $display("FAIL mid.addr: got %0d want %0d", read_address, e.addr); end
    end
    n_checks++; if (read_address !== ((INS_ON != 0) ? 5'd9 : 5'd10)) begin
      n_fail++; $display("FAIL mid.pre_reset_addr: got %0d want %0d", read_address, (INS_ON != 0) ? 9 : 10);
    end
    n_checks++; if (Skp_Added !== INS_ON[0]) begin n_fail++; $display("FAIL mid.pre_reset_skp: got %0b want %0b", Skp_Added, INS_ON[0]); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (read_address !== 5'd0) begin n_fail++; $display("FAIL areset.addr: got %0d want 0", read_address); end
    n_checks++; if (Skp_Added !== 1'b0) begin n_fail++; $display("FAIL areset.skp: got %0b want 0", Skp_Added); end
    n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL areset.underflow: got %0b want 0", underflow); end
    n_checks++; if (gray_read_pointer !== 5'd0) begin n_fail++; $display("FAIL areset.gray: got %0d want 0", gray_read_pointer); end
    n_checks++; if (occupancy !== 5'd0) begin n_fail++; $display("FAIL areset.occ: got %0d want 0", occupancy); end
    model_reset();
    mem[9] = NONSKP;
    mem[0] = SKP_P;
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin drive_cycle(1'b0, 1'b0, 5'd3); e = sb.pop_front(); end
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b1, 1'b0, 5'd3);
      e = sb.pop_front();
      if (Skp_Added === 1'b1) pulses++;
      n_checks++; if (read_address !== e.addr) begin n_fail++; $display("FAIL post.addr: got %0d want %0d", read_address, e.addr); end
      n_checks++; if (Skp_Added !== e.skp) begin n_fail++; $display("FAIL post.skp_added: got %0b want %0b", Skp_Added, e.skp); end
    end
    n_checks++; if (pulses != INS_ON) begin n_fail++; $display("FAIL post.count: got %0d want %0d", pulses, INS_ON); end
    n_checks++; if (read_address !== 5'd3) begin n_fail++; $display("FAIL post.final_addr: got %0d want 3", read_address); end
    mem[0] = NONSKP;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = NONSKP;
    test_reset();
    test_fill_drain();
    test_skp_insert();
    test_no_insert();
    test_wrap();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/read_pointer_control.md
# read_pointer_control

Read-side pointer control for the RX elastic buffer, running in the recovered-to-local read clock domain. It owns the binary read address and its Gray image, and it synchronises the Gray write pointer from the write domain. It flags empty/underflow and, in nominal-half-full mode, inserts SKP symbols by re-reading a SKP when buffer occupancy is low. It is the counterpart of the write-side pointer control, which handles full/overflow and SKP removal.

## Interface
- DATA_WIDTH, 10, symbol width; the SKP encodings below assume 10.
- BUFFER_DEPTH, 16, buffer entries; power of two, ≥4. A = $clog2(BUFFER_DEPTH).
- LOW_WATERMARK, 6, SKP insertion is eligible when occupancy < this value.

Ports (clock and reset first):
- read_clk  in  1  read-domain clock; all state is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- gray_write_pointer  in  A+1  Gray write pointer from the write domain (asynchronous).
- read_data  in  DATA_WIDTH  buffer symbol currently at read_address[A-1:0].
- read_enable  in  1  consumer requests one symbol this cycle.
- buffer_mode  in  1  0 = nominal half-full (SKP insertion allowed); 1 = nominal empty (no insertion).
- underflow  out  1  buffer empty (combinational); forced 0 while rst_n=0.
- Skp_Added  out  1  registered; 1 for the cycle after a SKP re-read was scheduled.
- read_address  out  A+1  binary read pointer, including the wrap bit.
- gray_read_pointer  out  A+1  Gray form of read_address (combinational), sent to the write domain.
- occupancy  out  A+1  (sync_wp_bin − read_address) mod 2^(A+1) (combinational).

## Operation
- Synchroniser: two-flop chain on gray_write_pointer, both stages reset to 0. The result, sync_gwp, is converted Gray→binary to give sync_wp_bin.
- empty = (gray_read_pointer == sync_gwp). underflow = empty when rst_n=1.
- SKP symbol = read_data ∈ {10'b0011111001, 10'b1100000110}.
- hold_flag register, reset 0: marks that the current SKP has already been duplicated.
- insert = read_enable & !empty & (buffer_mode==0) & SKP symbol & (occupancy < LOW_WATERMARK) & !hold_flag.
- Each cycle, if read_enable & !empty:
  - insert=1: read_address holds, hold_flag←1, Skp_Added←1.
  - otherwise: read_address←read_address+1 (wraps naturally at 2^(A+1)), hold_flag←0, Skp_Added←0.
- If read_enable & empty: read_address holds, Skp_Added←0, hold_flag unchanged.
- If !read_enable: everything holds, and Skp_Added←0.
- A SKP is never duplicated more than once. The next read of the same entry advances the pointer.

## Timing
- Reset values: read_address=0, Skp_Added=0, hold_flag=0, sync stages=0. Hence gray_read_pointer=0, occupancy=0, underflow=0 during reset and underflow=1 immediately after release.
- A write-pointer change becomes visible in empty/occupancy 2 read_clk edges after it is stable at the input.
- A pointer advance is visible on gray_read_pointer in the same cycle as read_address (no extra register).
- Skp_Added rises one edge after the insert decision and lasts exactly one cycle per insertion.
- Reset asserted mid-stream clears all state asynchronously. Pending holds are discarded.
- Wrap: 15→16 at depth 16 flips the MSB; read_address then continues 31→0.
- Empty is conservative, since the write pointer is seen late. Full detection belongs to the write side.

## Configuration
- EB_SKP_INSERT_EN defined: SKP insertion logic (hold_flag, insert, Skp_Added register) is built as above.
- Not defined: no insertion logic is built. Skp_Added is tied to 0, and the pointer advances on every read_enable & !empty, regardless of buffer_mode and LOW_WATERMARK.

## Test plan
- Reset then idle: gray_write_pointer=0 → underflow=1, read_address=0, Skp_Added=0. Asserting read_enable does not move the pointer.
- Write pointer at Gray of 5 (binary 5), read_enable held, read_data non-SKP → occupancy reaches 5 two edges later. read_address steps 0→5, then underflow=1 and the pointer stops.
- Macro on, buffer_mode=0, occupancy=3, read_data=10'b0011111001, read_enable=1 → address holds one cycle, Skp_Added=1 for one cycle, then address advances. Hold a SKP across ≥3 cycles → exactly one duplication.
- Same stimulus with buffer_mode=1 or occupancy=8 → no hold and Skp_Added stays 0. With the macro undefined and buffer_mode=0, occupancy=3 → also no hold.
- Wrap: stream 40 symbols with the writer 4 ahead → read_address passes 15→16→31→0. gray_read_pointer always differs in one bit per step, and underflow never asserts.
- Reset mid-stream at read_address=9, with hold_flag=1 → all outputs return to reset values asynchronously. After release, the first SKP is eligible for insertion again.
